// File: rtl/mem_access_ctrl_if.sv
// Signal bundle between the MEM stage, the load/store controller and the byte-lane data RAM.
// The controller connects through the slave modport; the pipeline/RAM side uses master.
interface mem_access_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              stall_o;
  logic              ram_ce;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_sel;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, resp_ready, ram_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall_o,
    output ram_ce, ram_we, ram_addr, ram_sel, ram_wdata
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, resp_ready, ram_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall_o,
    input  ram_ce, ram_we, ram_addr, ram_sel, ram_wdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store controller between the MEM stage and a big-endian byte-lane data RAM.
// Optional misalignment detection is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned ADDR_W      = 32
) (
  input logic              clk,
  input logic              rst,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [1:0]        off_q, off_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              ram_ce_q, ram_ce_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [3:0]        ram_sel_q, ram_sel_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;

  logic        req_byte, req_half, req_store, req_misaligned;
  logic [3:0]  req_sel;
  logic [31:0] req_wrep;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Request decode: lane selects and replicated store data.
  always_comb begin
    req_byte  = bus.req_op inside {3'b000, 3'b001, 3'b101};
    req_half  = bus.req_op inside {3'b010, 3'b011, 3'b110};
    req_store = bus.req_op[2] && (bus.req_op[1:0] != 2'b00);
    if (req_byte) begin
      req_sel  = 4'b1000 >> bus.req_addr[1:0];
      req_wrep = {4{bus.req_wdata[7:0]}};
    end else if (req_half) begin
      req_sel  = bus.req_addr[1] ? 4'b0011 : 4'b1100;
      req_wrep = {2{bus.req_wdata[15:0]}};
    end else begin
      req_sel  = 4'b1111;
      req_wrep = bus.req_wdata;
    end
`ifdef MEM_ALIGN_CHECK_EN
    req_misaligned = (req_half && bus.req_addr[0]) ||
                     (!req_byte && !req_half && (bus.req_addr[1:0] != 2'b00));
`else
    req_misaligned = 1'b0;
`endif
  end

  // Byte offset 0 sits in bits 31:24.
  always_comb begin
    ld_byte = 8'(bus.ram_rdata >> {~off_q, 3'b000});
    ld_half = off_q[1] ? bus.ram_rdata[15:0] : bus.ram_rdata[31:16];
    case (op_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {24'h0, ld_byte};
      3'b010:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b011:  ld_data = {16'h0, ld_half};
      3'b100:  ld_data = bus.ram_rdata;
      default: ld_data = 32'h0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    off_d        = off_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    ram_ce_d     = ram_ce_q;
    ram_we_d     = ram_we_q;
    ram_addr_d   = ram_addr_q;
    ram_sel_d    = ram_sel_q;
    ram_wdata_d  = ram_wdata_q;
    unique case (state_q)
      StIdle: begin
        req_ready_d = 1'b1;
        if (req_ready_q && bus.req_valid) begin
          req_ready_d = 1'b0;
          op_d        = bus.req_op;
          off_d       = bus.req_addr[1:0];
          cnt_d       = WaitInit;
          if (req_misaligned) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
          end else begin
            state_d     = StAccess;
            ram_ce_d    = 1'b1;
            ram_we_d    = req_store;
            ram_addr_d  = {bus.req_addr[ADDR_W-1:2], 2'b00};
            ram_sel_d   = req_sel;
            ram_wdata_d = req_wrep;
          end
        end
      end
      StAccess: begin
        if (cnt_q == 4'd0) begin
          state_d      = StResp;
          ram_ce_d     = 1'b0;
          ram_we_d     = 1'b0;
          ram_sel_d    = 4'b0000;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = ld_data;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (bus.resp_ready) begin
          state_d      = StIdle;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      op_q         <= 3'd0;
      off_q        <= 2'd0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      ram_ce_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_sel_q    <= 4'b0000;
      ram_wdata_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      off_q        <= off_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      ram_ce_q     <= ram_ce_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_sel_q    <= ram_sel_d;
      ram_wdata_q  <= ram_wdata_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.ram_ce     = ram_ce_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_sel    = ram_sel_q;
  assign bus.ram_wdata  = ram_wdata_q;
  // The accept cycle itself stalls, before the FSM leaves IDLE.
  assign bus.stall_o    = (state_q != StIdle) || (bus.req_valid && req_ready_q);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed plus random bench for mem_access_ctrl against a byte-arithmetic memory model.
module tb_mem_access_ctrl;
  localparam int unsigned Wait = 2;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit AlignEn = 1'b1;
`else
  localparam bit AlignEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mem_access_ctrl_if #(.ADDR_W(32)) bus ();

  mem_access_ctrl #(.WAIT_CYCLES(Wait), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] ram    [256];
  logic [31:0] shadow [256];

  function automatic logic [31:0] init_word(int i);
    if (i == 32'h40) return 32'h80FF7F01;
    if (i == 32'h80) return 32'h12345678;
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Environment RAM: combinational read, byte-lane write on the clock.
  assign bus.ram_rdata = ram[bus.ram_addr[9:2]];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
    end else if (bus.ram_ce && bus.ram_we) begin
      for (int k = 0; k < 4; k++)
        if (bus.ram_sel[k]) ram[bus.ram_addr[9:2]][8*k +: 8] <= bus.ram_wdata[8*k +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic int op_size(logic [2:0] op);
    if (op == 3'd0 || op == 3'd1 || op == 3'd5) return 1;
    if (op == 3'd2 || op == 3'd3 || op == 3'd6) return 2;
    return 4;
  endfunction

  // First byte index (0 = MSB lane) covered by an access of the given size.
  function automatic int lane_start(int size, logic [31:0] addr);
    return (int'(addr % 4) / size) * size;
  endfunction

  function automatic logic [31:0] model_load(logic [2:0] op, int size, int start,
                                             logic [31:0] word);
    longint v;
    v = (longint'(word) >> (8 * (4 - start - size))) & ((longint'(1) << (8 * size)) - 1);
    if ((op == 3'd0 || op == 3'd2) && v >= (longint'(1) << (8 * size - 1)))
      v = v - (longint'(1) << (8 * size));
    return 32'(v);
  endfunction

  // Issue one request, follow it to its response, hold it for 'hold' cycles, then take it.
  task automatic run_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input int hold);
    int          size, start, idx, cyc, ce_cnt, exp_ce;
    logic        st, mis;
    logic [3:0]  esel;
    logic [31:0] ewd, erd;
    size  = op_size(op);
    st    = (op >= 3'd5);
    mis   = AlignEn && ((size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00));
    start = lane_start(size, addr);
    esel  = 4'b0000;
    for (int k = start; k < start + size; k++) esel[3-k] = 1'b1;
    ewd    = (size == 4) ? wd : (size == 2) ? {2{wd[15:0]}} : {4{wd[7:0]}};
    idx    = int'(addr[9:2]);
    erd    = (st || mis) ? 32'h0 : model_load(op, size, start, shadow[idx]);
    exp_ce = mis ? 0 : int'(Wait) + 1;

    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    #1;
    chk1("accept_ready", bus.req_ready, 1'b1);
    chk1("accept_stall", bus.stall_o, 1'b1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    cyc    = 1;
    ce_cnt = 0;
    while (!bus.resp_valid && cyc < 40) begin
      chk1("busy_stall", bus.stall_o, 1'b1);
      chk1("busy_ready", bus.req_ready, 1'b0);
      if (bus.ram_ce) begin
        ce_cnt++;
        chk("ram_addr", bus.ram_addr, {addr[31:2], 2'b00});
        chk("ram_sel", 32'(bus.ram_sel), 32'(esel));
        chk1("ram_we", bus.ram_we, st);
        if (st) chk("ram_wdata", bus.ram_wdata, ewd);
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk1("resp_valid", bus.resp_valid, 1'b1);
    chk("resp_latency", cyc, exp_ce + 1);
    chk("ce_cycles", ce_cnt, exp_ce);
    chk("resp_rdata", bus.resp_rdata, erd);
    chk1("resp_err", bus.resp_err, mis);
    chk1("resp_ce_low", bus.ram_ce, 1'b0);
    chk("resp_sel_low", 32'(bus.ram_sel), 32'h0);
    if (st && !mis)
      for (int k = start; k < start + size; k++) shadow[idx][31-8*k -: 8] = ewd[31-8*k -: 8];
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk1("hold_valid", bus.resp_valid, 1'b1);
      chk("hold_rdata", bus.resp_rdata, erd);
      chk1("hold_stall", bus.stall_o, 1'b1);
      chk1("hold_ready", bus.req_ready, 1'b0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk1("taken_valid", bus.resp_valid, 1'b0);
    chk1("taken_ready", bus.req_ready, 1'b1);
    chk1("taken_stall", bus.stall_o, 1'b0);
  endtask

  initial begin
    int          cyc, rdy_cyc;
    logic        resp_seen;
    logic [31:0] d;
    bus.req_valid  = 1'b0;
    bus.req_op     = 3'd0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);

    // Reset values.
    #2 rst = 1'b1;
    #1;
    chk1("rst_req_ready", bus.req_ready, 1'b0);
    chk1("rst_resp_valid", bus.resp_valid, 1'b0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk1("rst_resp_err", bus.resp_err, 1'b0);
    chk1("rst_stall", bus.stall_o, 1'b0);
    chk1("rst_ram_ce", bus.ram_ce, 1'b0);
    chk1("rst_ram_we", bus.ram_we, 1'b0);
    chk("rst_ram_addr", bus.ram_addr, 32'h0);
    chk("rst_ram_sel", 32'(bus.ram_sel), 32'h0);
    chk("rst_ram_wdata", bus.ram_wdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk1("release_ready_low", bus.req_ready, 1'b0);
    @(posedge clk); #1;
    chk1("release_ready_high", bus.req_ready, 1'b1);

    // Directed accesses.
    run_req(3'd5, 32'h0000_0102, 32'h0000_00A5, 0);
    run_req(3'd0, 32'h0000_0100, 32'h0, 0);
    run_req(3'd1, 32'h0000_0101, 32'h0, 0);
    run_req(3'd2, 32'h0000_0102, 32'h0, 0);
    run_req(3'd3, 32'h0000_0100, 32'h0, 0);
    run_req(3'd4, 32'h0000_0200, 32'h0, 5);
    run_req(3'd4, 32'h0000_0202, 32'h0, 0);

    // Back-to-back SW then LW with req_valid held high.
    d = 32'hCAFE_F00D;
    bus.req_valid  = 1'b1;
    bus.req_op     = 3'd7;
    bus.req_addr   = 32'h10;
    bus.req_wdata  = d;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_op = 3'd4;
    resp_seen  = 1'b0;
    rdy_cyc    = 0;
    for (cyc = 1; cyc < 30; cyc++) begin
      if (bus.resp_valid) begin
        resp_seen = 1'b1;
        chk("b2b_store_rdata", bus.resp_rdata, 32'h0);
      end
      if (bus.req_ready) begin
        rdy_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    chk1("b2b_first_resp_seen", resp_seen, 1'b1);
    chk("b2b_reaccept_cycle", rdy_cyc, int'(Wait) + 3);
    shadow[4] = d;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    cyc = 0;
    while (!bus.resp_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk1("b2b_load_valid", bus.resp_valid, 1'b1);
    chk("b2b_load_rdata", bus.resp_rdata, d);
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk1("b2b_idle_ready", bus.req_ready, 1'b1);

    // Random traffic over the low 1 KiB.
    for (int n = 0; n < 60; n++)
      run_req(3'($urandom_range(0, 7)), 32'($urandom_range(0, 1023)), $urandom,
              int'($urandom_range(0, 2)));

    // Reset in the middle of a store access.
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd7;
    bus.req_addr  = 32'h3FC;
    bus.req_wdata = 32'h1357_9BDF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk1("mid_ce_on", bus.ram_ce, 1'b1);
    chk1("mid_we_on", bus.ram_we, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk1("mid_rst_ce", bus.ram_ce, 1'b0);
    chk1("mid_rst_we", bus.ram_we, 1'b0);
    chk1("mid_rst_valid", bus.resp_valid, 1'b0);
    chk1("mid_rst_stall", bus.stall_o, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk1("mid_rel_ready_low", bus.req_ready, 1'b0);
    @(posedge clk); #1;
    chk1("mid_rel_ready", bus.req_ready, 1'b1);
    chk1("mid_rel_no_resp", bus.resp_valid, 1'b0);
    chk1("mid_rel_ce", bus.ram_ce, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
